// File: rtl/userkey_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : userkey_ctrl
// Purpose  : Key synchroniser/debouncer with sticky press flags, maskable IRQ
//            and a 4-word memory-mapped register interface.
// Revision : 1.0
// ============================================================================
module userkey_ctrl #(
   parameter int NUM_KEYS        = 8,
   parameter int DEBOUNCE_CYCLES = 20000,
   parameter int CNT_WIDTH       = 15,
   parameter int ACTIVE_LOW      = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_KEYS-1:0] user_key,
   input  logic [1:0]          addr,
   input  logic                we,
   input  logic [31:0]         WD,
   output logic [31:0]         RD,
   output logic                irq
);

   localparam logic [1:0]           ADDR_LEVEL = 2'd0;
   localparam logic [1:0]           ADDR_PEND  = 2'd1;
   localparam logic [1:0]           ADDR_MASK  = 2'd2;
   localparam logic [CNT_WIDTH-1:0] CNT_LAST   = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   logic [NUM_KEYS-1:0] key_in;
   logic [NUM_KEYS-1:0] sync1;
   logic [NUM_KEYS-1:0] sync2;
   logic [NUM_KEYS-1:0] level;
   logic [NUM_KEYS-1:0] press;
   logic [NUM_KEYS-1:0] pending;
   logic [NUM_KEYS-1:0] mask;
   logic [NUM_KEYS-1:0] clr_bits;
   logic                wr_pend;
   logic                wr_mask;
   logic [31:0]         rd_data;
   logic                unused_wd_hi;

   // Normalise polarity so that 1 always means pressed from here on.
   assign key_in = (ACTIVE_LOW != 0) ? ~user_key : user_key;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= key_in;
         sync2 <= sync1;
      end
   end

   generate
      for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
         logic [CNT_WIDTH-1:0] cnt;
         logic                 st;
         logic                 expired;

         assign expired = (cnt == CNT_LAST);

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               cnt <= '0;
               st  <= 1'b0;
            end else if (sync2[i] == st) begin
               cnt <= '0;
            end else if (expired) begin
               st  <= sync2[i];
               cnt <= '0;
            end else begin
               cnt <= cnt + CNT_WIDTH'(1);
            end
         end

         assign level[i] = st;
         // Fires on the very edge where st is about to rise.
         assign press[i] = sync2[i] & ~st & expired;
      end
   endgenerate

   assign wr_pend  = we && (addr == ADDR_PEND);
   assign wr_mask  = we && (addr == ADDR_MASK);
   assign clr_bits = wr_pend ? WD[NUM_KEYS-1:0] : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending <= '0;
         mask    <= '0;
      end else begin
         // A new press overrides a coincident write-1-to-clear.
         pending <= (pending & ~clr_bits) | press;
         if (wr_mask) begin
            mask <= WD[NUM_KEYS-1:0];
         end
      end
   end

   always_comb begin
      rd_data = '0;
      case (addr)
         ADDR_LEVEL: rd_data[NUM_KEYS-1:0] = level;
         ADDR_PEND:  rd_data[NUM_KEYS-1:0] = pending;
         ADDR_MASK:  rd_data[NUM_KEYS-1:0] = mask;
         default:    rd_data = '0;
      endcase
   end

   assign RD           = rd_data;
   assign irq          = |(pending & mask);
   assign unused_wd_hi = ^WD;

endmodule
`default_nettype wire

// File: tb/tb_userkey_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_userkey_ctrl
// Purpose  : Directed and randomised bench for userkey_ctrl with a window
//            based reference model.
// Revision : 1.0
// ============================================================================
module tb_userkey_ctrl;

   localparam int NK = 8;
   localparam int DB = 4;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic [NK-1:0] user_key;
   logic [1:0]    addr;
   logic          we;
   logic [31:0]   WD;
   logic [31:0]   RD;
   logic          irq;

   int checks = 0;
   int errors = 0;

   logic [NK-1:0] m_st;
   logic [NK-1:0] m_pend;
   logic [NK-1:0] m_mask;
   logic [NK-1:0] hist [0:DB];

   userkey_ctrl #(
      .NUM_KEYS        (NK),
      .DEBOUNCE_CYCLES (DB),
      .CNT_WIDTH       (CW),
      .ACTIVE_LOW      (1)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .user_key (user_key),
      .addr     (addr),
      .we       (we),
      .WD       (WD),
      .RD       (RD),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_rd(input logic [1:0] a);
      logic [31:0] r;
      r = '0;
      case (a)
         2'd0:    r[NK-1:0] = m_st;
         2'd1:    r[NK-1:0] = m_pend;
         2'd2:    r[NK-1:0] = m_mask;
         default: r = '0;
      endcase
      return r;
   endfunction

   task automatic model_reset();
      m_st   = '0;
      m_pend = '0;
      m_mask = '0;
      for (int j = 0; j <= DB; j++) hist[j] = '0;
   endtask

   // hist[j] is the pressed-state sampled j+1 edges ago; a key flips once the
   // synchronised samples of the last DB edges all disagree with its level.
   task automatic model_edge();
      logic [NK-1:0] new_st;
      logic [NK-1:0] rise;
      logic [NK-1:0] clr;
      logic          all_diff;
      if (reset) begin
         model_reset();
         return;
      end
      new_st = m_st;
      for (int i = 0; i < NK; i++) begin
         all_diff = 1'b1;
         for (int j = 1; j <= DB; j++) begin
            if (hist[j][i] == m_st[i]) all_diff = 1'b0;
         end
         if (all_diff) new_st[i] = ~m_st[i];
      end
      rise   = new_st & ~m_st;
      clr    = (we && addr == 2'd1) ? WD[NK-1:0] : '0;
      m_pend = (m_pend & ~clr) | rise;
      if (we && addr == 2'd2) m_mask = WD[NK-1:0];
      m_st = new_st;
      for (int j = DB; j >= 1; j--) hist[j] = hist[j-1];
      hist[0] = ~user_key;
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      check("rd_model", RD, exp_rd(addr));
      check("irq_model", {31'b0, irq}, {31'b0, |(m_pend & m_mask)});
      @(negedge clk);
      we = 1'b0;
   endtask

   task automatic cycles(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      addr = a;
      WD   = d;
      we   = 1'b1;
      cycle();
   endtask

   task automatic rd_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
      addr = a;
      #1;
      check(tag, RD, exp);
   endtask

   initial begin
      reset    = 1'b1;
      user_key = NK'($urandom);
      addr     = 2'd0;
      we       = 1'b0;
      WD       = '0;
      model_reset();
      @(negedge clk);
      cycles(2);
      rd_check("reset_a0", 2'd0, 32'h0);
      rd_check("reset_a1", 2'd1, 32'h0);
      rd_check("reset_a2", 2'd2, 32'h0);
      check("reset_irq", {31'b0, irq}, 32'h0);

      user_key = '1;
      reset    = 1'b0;
      cycles(8);

      // Clean press of key 3: level rises on the sixth sampling edge.
      addr        = 2'd0;
      user_key[3] = 1'b0;
      for (int e = 1; e <= 6; e++) begin
         cycle();
         check($sformatf("press_e%0d", e), RD, (e < 6) ? 32'h0 : 32'h08);
      end
      rd_check("press_pend", 2'd1, 32'h08);
      check("press_irq", {31'b0, irq}, 32'h0);
      user_key[3] = 1'b1;
      cycles(8);
      wr(2'd1, 32'hFF);

      // Glitches of three cycles on key 0.
      for (int g = 0; g < 5; g++) begin
         user_key[0] = 1'b0;
         cycles(3);
         user_key[0] = 1'b1;
         cycles(3);
      end
      rd_check("glitch_level", 2'd0, 32'h0);
      rd_check("glitch_pend", 2'd1, 32'h0);

      // IRQ and write-1-to-clear.
      wr(2'd2, 32'h08);
      user_key[3] = 1'b0;
      cycles(8);
      rd_check("irq_pend", 2'd1, 32'h08);
      check("irq_set", {31'b0, irq}, 32'h1);
      wr(2'd1, 32'h01);
      check("w1c_other", RD, 32'h08);
      check("w1c_other_irq", {31'b0, irq}, 32'h1);
      wr(2'd1, 32'h08);
      check("w1c_hit", RD, 32'h0);
      check("w1c_hit_irq", {31'b0, irq}, 32'h0);
      user_key[3] = 1'b1;
      cycles(8);
      rd_check("release_pend", 2'd1, 32'h0);

      // W1C of bit 5 on the edge where its level rises.
      user_key[5] = 1'b0;
      cycles(5);
      wr(2'd1, 32'h20);
      check("collide_pend", RD, 32'h20);
      rd_check("collide_level", 2'd0, 32'h20);
      user_key[5] = 1'b1;
      cycles(8);
      wr(2'd1, 32'hFF);
      wr(2'd2, 32'h00);

      // Reset in the middle of qualifying key 7.
      user_key[7] = 1'b0;
      cycles(4);
      reset = 1'b1;
      model_reset();
      rd_check("midrst_a0", 2'd0, 32'h0);
      rd_check("midrst_a1", 2'd1, 32'h0);
      check("midrst_irq", {31'b0, irq}, 32'h0);
      addr = 2'd0;
      cycle();
      reset = 1'b0;
      for (int e = 1; e <= 6; e++) begin
         cycle();
         check($sformatf("requal_e%0d", e), RD, (e < 6) ? 32'h0 : 32'h80);
      end
      rd_check("requal_pend", 2'd1, 32'h80);
      user_key[7] = 1'b1;
      cycles(8);

      // Randomised traffic against the reference model.
      for (int n = 0; n < 4000; n++) begin
         int rate;
         rate = ((n / 500) % 2 == 0) ? 3 : 12;
         for (int i = 0; i < NK; i++) begin
            if ($urandom_range(0, rate - 1) == 0) user_key[i] = ~user_key[i];
         end
         addr = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) begin
            we = 1'b1;
            WD = $urandom;
         end
         if ($urandom_range(0, 599) == 0) begin
            reset = 1'b1;
            model_reset();
            #1;
            check("rand_rst_rd", RD, 32'h0);
            check("rand_rst_irq", {31'b0, irq}, 32'h0);
            cycle();
            reset = 1'b0;
         end else begin
            cycle();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
